// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux_arb round-robin arbiter.
package mux_arb_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STAT_W = 8;

  // Source encoding used for the mux select and the round-robin pointer.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  // Contents of the one-entry output register: originating source and word.
  typedef struct packed {
    logic             src;
    logic [WIDTH-1:0] data;
  } cap_t;

  // Saturating increment for the grant statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mux_arb_rr_pick2.sv
// Combinational two-way round-robin picker; a tie goes to the source
// opposite the one that won last.
module rr_pick2
  import mux_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic valid,
  output logic winner
);

  // Winner selection: single requester wins outright, tie alternates.
  always_comb begin
    valid  = req_a | req_b;
    winner = SRC_A;
    if (req_a && req_b) begin
      winner = (last == SRC_A) ? SRC_B : SRC_A;
    end else if (req_b) begin
      winner = SRC_B;
    end
  end

endmodule

// File: rtl/mux_arb.sv
// Round-robin arbiter for the shared 2:1 mux datapath with a one-entry
// valid/ready output register. Optional grant statistics (count_a/count_b)
// are built when MUX_ARB_STATS_EN is defined.
module mux_arb
  import mux_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] count_a,
  output logic [STAT_W-1:0] count_b
`endif
);

  state_e state_q, state_d;
  cap_t   cap_q, cap_d;
  logic   last_q, last_d;
  logic   pick_valid;
  logic   pick_winner;
  logic   can_load;
  logic   capture;

  rr_pick2 u_pick (
    .req_a  (req_a),
    .req_b  (req_b),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Load decision, grants and next-state; no grant while reset is asserted.
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    last_d   = last_q;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    can_load = (state_q == IDLE) || ((state_q == FULL) && out_ready);
    capture  = !reset && can_load && pick_valid;

    if (capture) begin
      gnt_a      = (pick_winner == SRC_A);
      gnt_b      = (pick_winner == SRC_B);
      cap_d.src  = pick_winner;
      cap_d.data = (pick_winner == SRC_B) ? data_b : data_a;
      last_d     = pick_winner;
    end

    case (state_q)
      IDLE:    if (capture) state_d = FULL;
      FULL:    if (out_ready && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, output register and round-robin pointer; B starts as last so A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q   <= '0;
      last_q  <= SRC_B;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = cap_q.data;
  assign sel       = cap_q.src;

`ifdef MUX_ARB_STATS_EN
  logic [STAT_W-1:0] count_a_q, count_b_q;

  // Per-source capture counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_a_q <= '0;
      count_b_q <= '0;
    end else begin
      if (gnt_a) count_a_q <= sat_inc(count_a_q);
      if (gnt_b) count_b_q <= sat_inc(count_b_q);
    end
  end

  assign count_a = count_a_q;
  assign count_b = count_b_q;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: the stimulus side predicts grants and queues
// expected words; a negedge monitor checks every word the consumer accepts.
module tb_mux_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] data_a = 4'h0, data_b = 4'h0;
  logic       gnt_a, gnt_b, sel, out_valid;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;
`ifdef MUX_ARB_STATS_EN
  logic [7:0] count_a, count_b;
`endif

  mux_arb dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .gnt_a     (gnt_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
    ,
    .count_a   (count_a),
    .count_b   (count_b)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: buffer occupancy, last winner (0=A,1=B), capture counts.
  bit          m_occ   = 1'b0;
  bit          m_last  = 1'b1;
  int          m_cnt_a = 0;
  int          m_cnt_b = 0;
  logic [4:0]  sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each accepted word must match the oldest predicted capture.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty: got word %0h expected none at %0t", out_data, $time);
      end else begin
        logic [4:0] e;
        e = sb_q.pop_front();
        chk("sb_data", int'(out_data), int'(e[3:0]));
        chk("sb_sel", int'(sel), int'(e[4]));
      end
    end
  end

  // One cycle of stimulus; exp_d/exp_s >= 0 also checks the registered output.
  task automatic step(input bit ra, input logic [3:0] da, input bit rb, input logic [3:0] db,
                      input bit rdy, input int exp_d, input int exp_s,
                      output bit ga, output bit gb);
    bit can;
    @(posedge clk); #1;
    reset = 1'b0; req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rdy;
    #1;
    chk("out_valid", int'(out_valid), int'(m_occ));
    if (exp_d >= 0) chk("out_data", int'(out_data), exp_d);
    if (exp_s >= 0) chk("sel", int'(sel), exp_s);
    can = !m_occ || rdy;
    // Single requester wins; on a tie the source that did not win last time wins.
    ga  = can && ra && (!rb || m_last == 1'b1);
    gb  = can && rb && (!ra || m_last == 1'b0);
    chk("gnt_a", int'(gnt_a), int'(ga));
    chk("gnt_b", int'(gnt_b), int'(gb));
    if (ga) begin sb_q.push_back({1'b0, da}); m_last = 1'b0; if (m_cnt_a < 255) m_cnt_a++; end
    if (gb) begin sb_q.push_back({1'b1, db}); m_last = 1'b1; if (m_cnt_b < 255) m_cnt_b++; end
    if (ga || gb) m_occ = 1'b1;
    else if (rdy) m_occ = 1'b0;
  endtask

  // Hold reset for n cycles with the given requests, then one quiet cycle.
  task automatic do_reset(input int n, input bit ra, input bit rb);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1; req_a = ra; req_b = rb; out_ready = 1'b1;
      #1;
      chk("rst_gnt_a", int'(gnt_a), 0);
      chk("rst_gnt_b", int'(gnt_b), 0);
    end
    m_occ = 1'b0; m_last = 1'b1; m_cnt_a = 0; m_cnt_b = 0;
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_sel", int'(sel), 0);
`ifdef MUX_ARB_STATS_EN
    chk("rst_count_a", int'(count_a), 0);
    chk("rst_count_b", int'(count_b), 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ga, gb;
    bit pa, pb;
    logic [3:0] da, db;

    do_reset(2, 1'b1, 1'b1);

    // Single source
    step(1, 4'hA, 0, 4'h0, 1, -1, -1, ga, gb);
    chk("single_gnt_a", int'(ga), 1);
    step(0, 4'h0, 0, 4'h0, 1, 'hA, 0, ga, gb);

    // Tie fairness: 3,C,3,C,3,C
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1, 4'h3, 1, 4'hC, 1, (i == 0) ? -1 : ((i % 2) ? 'h3 : 'hC),
           (i == 0) ? -1 : ((i % 2) ? 0 : 1), ga, gb);
    end
    step(0, 4'h0, 0, 4'h0, 1, 'hC, 1, ga, gb);

    // Backpressure
    step(0, 4'h0, 1, 4'h5, 1, -1, -1, ga, gb);
    for (int i = 0; i < 4; i++) step(1, 4'h9, 0, 4'h0, 0, 'h5, 1, ga, gb);
    step(1, 4'h9, 0, 4'h0, 1, 'h5, 1, ga, gb);
    chk("bp_release_gnt_a", int'(ga), 1);
    step(0, 4'h0, 0, 4'h0, 1, 'h9, 0, ga, gb);

    // Reset mid-operation discards the buffered word; next tie goes to A
    step(1, 4'h7, 0, 4'h0, 0, -1, -1, ga, gb);
    step(0, 4'h0, 0, 4'h0, 0, 'h7, 0, ga, gb);
    do_reset(1, 1'b1, 1'b1);
    step(1, 4'h1, 1, 4'h2, 1, -1, -1, ga, gb);
    chk("post_rst_tie_a", int'(ga), 1);
    step(0, 4'h0, 0, 4'h0, 1, 'h1, 0, ga, gb);

    // Randomized traffic; a waiting requester keeps its word stable
    pa = 0; pb = 0; da = 0; db = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pa) begin pa = ($urandom_range(0, 99) < 60); da = 4'($urandom); end
      if (!pb) begin pb = ($urandom_range(0, 99) < 60); db = 4'($urandom); end
      step(pa, da, pb, db, ($urandom_range(0, 99) < 70), -1, -1, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    for (int i = 0; i < 3; i++) step(0, 4'h0, 0, 4'h0, 1, -1, -1, ga, gb);
    chk("sb_drained", sb_q.size(), 0);
`ifdef MUX_ARB_STATS_EN
    chk("rand_count_a", int'(count_a), m_cnt_a);
    chk("rand_count_b", int'(count_b), m_cnt_b);

    // Saturation: 300 back-to-back captures from A
    do_reset(1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1, 4'(i), 0, 4'h0, 1, -1, -1, ga, gb);
    step(0, 4'h0, 0, 4'h0, 1, -1, -1, ga, gb);
    chk("sat_count_a", int'(count_a), 255);
    chk("sat_count_b", int'(count_b), 0);
    chk("model_count_a", int'(count_a), m_cnt_a);
`endif

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
